// File: rtl/ecc32_pkg.sv
// Shared ECC32 definitions: check masks, widths and error-injection limits.
// The SEC decoder imports this package too, so both sides stay in step.
package ecc32_pkg;

  localparam int DATA_W          = 32;
  localparam int CHECK_W         = 8;
  localparam int INJ_POS_W       = 6;
  localparam int INJ_DATA_LAST   = 31;
  localparam int INJ_CHECK_FIRST = 32;
  localparam int INJ_CHECK_LAST  = 39;

  // Entry k selects the data bits covered by check bit k.
  localparam logic [CHECK_W-1:0][DATA_W-1:0] CHECK_MASK = {
    32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
    32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
  };

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [CHECK_W-1:0] check;
  } codeword_t;

  // Flip at most one codeword bit; positions beyond the check field are no-ops.
  function automatic codeword_t inject_error(codeword_t cw, logic en,
                                             logic [INJ_POS_W-1:0] pos);
    codeword_t r;
    r = cw;
    if (en) begin
      if (pos <= INJ_POS_W'(INJ_DATA_LAST))
        r.data[pos[4:0]] = ~cw.data[pos[4:0]];
      else if (pos <= INJ_POS_W'(INJ_CHECK_LAST))
        r.check[pos[2:0]] = ~cw.check[pos[2:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/ecc32_checkgen.sv
// Combinational check-bit generator: each check bit is the even parity of
// the data bits selected by its mask.
module ecc32_checkgen
  import ecc32_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  output logic [CHECK_W-1:0] check
);

  always_comb begin
    check = '0;
    for (int k = 0; k < CHECK_W; k++)
      check[k] = ^(data & CHECK_MASK[k]);
  end

endmodule

// File: rtl/ecc32_encoder.sv
// ECC32 encoder with a two-entry (output + skid) ready/valid pipeline,
// optional single-bit error injection and a saturating delivery counter.
module ecc32_encoder
  import ecc32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 inj_en,
  input  logic [INJ_POS_W-1:0] inj_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [CHECK_W-1:0]   out_check,
  output logic [CNT_W-1:0]     cw_count
);

  logic [CHECK_W-1:0] in_check;
  codeword_t          in_cw;
  codeword_t          out_cw;
  codeword_t          skid_cw;
  logic               skid_valid;
  logic               skid_valid_d;
  logic               accept;
  logic               pop;
  logic               out_free;

  ecc32_checkgen u_checkgen (
    .data  (in_data),
    .check (in_check)
  );

  // Check bits come from clean data; injection is applied afterwards.
  assign in_cw = inject_error('{data: in_data, check: in_check}, inj_en, inj_pos);

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

  // in_ready tracks skid emptiness one cycle ahead, so it stays registered
  // with no combinational path from out_ready.
  always_comb begin
    skid_valid_d = skid_valid;
    if (out_free)
      skid_valid_d = skid_valid && accept;
    else if (accept)
      skid_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_cw     <= '0;
      skid_valid <= 1'b0;
      skid_cw    <= '0;
      in_ready   <= 1'b0;
      cw_count   <= '0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_cw    <= skid_cw;
          if (accept)
            skid_cw <= in_cw;
        end else begin
          out_valid <= accept;
          if (accept)
            out_cw <= in_cw;
        end
      end else if (accept) begin
        skid_cw <= in_cw;
      end
      skid_valid <= skid_valid_d;
      in_ready   <= !skid_valid_d;
      if (pop && (cw_count != '1))
        cw_count <= cw_count + 1'b1;
    end
  end

  assign out_data  = out_cw.data;
  assign out_check = out_cw.check;

endmodule

// File: tb/tb_ecc32_encoder.sv
// Self-checking bench for ecc32_encoder: directed vector table plus
// hand-written backpressure, reset, streaming and saturation sequences.
module tb_ecc32_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        inj_en;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic [15:0] cw_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [7:0]  out_check4;
  logic [3:0]  cw_count4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [39:0] exp_q[$];
  bit          chk_syn = 0;

  always #5 clk = ~clk;

  ecc32_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_check(out_check), .cw_count(cw_count)
  );

  ecc32_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_check(out_check4), .cw_count(cw_count4)
  );

  localparam bit [31:0] MASKS [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  function automatic logic [7:0] calc_check(logic [31:0] d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) c[k] = ^(d & MASKS[k]);
    return c;
  endfunction

  function automatic logic [39:0] model_cw(logic [31:0] d, logic en, logic [5:0] pos);
    logic [31:0] dd;
    logic [7:0]  c;
    dd = d;
    c  = calc_check(d);
    if (en) begin
      if (pos < 6'd32)      dd[pos] = ~dd[pos];
      else if (pos < 6'd40) c[pos - 6'd32] = ~c[pos - 6'd32];
    end
    return {dd, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard the handshakes that happen at the coming edge.
  task automatic cycle();
    logic [39:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {out_data, out_check}, 40'h0);
        end else begin
          e = exp_q.pop_front();
          chk("order_word", {out_data, out_check}, e);
        end
        if (chk_syn) chk("syndrome", calc_check(out_data) ^ out_check, 8'h00);
      end
      if (in_valid && in_ready) exp_q.push_back(model_cw(in_data, inj_en, inj_pos));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (exp_q.size() != 0 || out_valid); i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    exp_q.delete();
    rst = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [5:0]  pos;
    logic [31:0] exp_data;
    logic [7:0]  exp_check;
  } vec_t;

  vec_t vecs [12];
  int acc_cnt;
  logic [31:0] w0;

  initial begin
    vecs[0]  = '{32'h00000000, 1'b0, 6'd0,  32'h00000000, 8'h00};
    vecs[1]  = '{32'h00000001, 1'b0, 6'd0,  32'h00000001, 8'h51};
    vecs[2]  = '{32'h80000000, 1'b0, 6'd0,  32'h80000000, 8'h8A};
    vecs[3]  = '{32'hFFFFFFFF, 1'b0, 6'd0,  32'hFFFFFFFF, 8'h00};
    vecs[4]  = '{32'h00000003, 1'b0, 6'd0,  32'h00000003, 8'h03};
    vecs[5]  = '{32'h0000FFFF, 1'b0, 6'd0,  32'h0000FFFF, 8'h00};
    vecs[6]  = '{32'h00000000, 1'b1, 6'd5,  32'h00000020, 8'h00};
    vecs[7]  = '{32'h00000000, 1'b1, 6'd37, 32'h00000000, 8'h20};
    vecs[8]  = '{32'h00000000, 1'b1, 6'd50, 32'h00000000, 8'h00};
    vecs[9]  = '{32'hFFFFFFFF, 1'b1, 6'd31, 32'h7FFFFFFF, 8'h00};
    vecs[10] = '{32'h00000000, 1'b1, 6'd39, 32'h00000000, 8'h80};
    vecs[11] = '{32'h00000001, 1'b1, 6'd32, 32'h00000001, 8'h50};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_check", out_check, 8'h0);
    chk("reset_cw_count", cw_count, 16'h0);
    rst = 1'b0;
    cycle();
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Directed vectors: one word at a time, 1-cycle latency.
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = vecs[i].data;
      inj_en    = vecs[i].en;
      inj_pos   = vecs[i].pos;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      cycle();
      in_valid = 1'b0; inj_en = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_out_check", i), out_check, vecs[i].exp_check);
      cycle();
    end
    chk("vec_cw_count", cw_count, 16'd12);

    // Backpressure: two accepts fill output + skid, then in_ready drops.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_cnt   = 0;
    w0        = 32'hA5A50001;
    in_data   = w0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, (c < 2) ? 1'b1 : 1'b0);
      if (c >= 1) begin
        chk($sformatf("bp_out_valid_c%0d", c), out_valid, 1'b1);
        chk($sformatf("bp_stable_c%0d", c), {out_data, out_check}, model_cw(w0, 1'b0, 6'd0));
      end
      if (in_ready) begin
        acc_cnt++;
        cycle();
        in_data = w0 + 32'(acc_cnt);
      end else begin
        cycle();
      end
    end
    chk("bp_accepted", acc_cnt, 2);
    drain();
    chk("bp_cw_count", cw_count, 16'd2);

    // Reset with two words buffered: they must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD0001; cycle();
    in_data   = 32'hDEAD0002; cycle();
    chk("rst_mid_skid_full", in_ready, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    exp_q.delete();
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_cw_count", cw_count, 16'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("rst_mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_mid_no_stale%0d", i), out_valid, 1'b0);
      cycle();
    end

    // 1000 random words at full rate.
    do_reset();
    chk_syn   = 1;
    out_ready = 1'b1;
    acc_cnt   = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      if (in_ready) acc_cnt++;
      cycle();
    end
    chk("stream_accepts", acc_cnt, 1000);
    drain();
    chk("stream_cw_count", cw_count, 16'd1000);
    chk_syn = 0;

    // Saturation of a narrow counter alongside the wide one.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i * 7919);
      cycle();
    end
    drain();
    chk("sat_cw_count4", cw_count4, 4'hF);
    chk("sat_cw_count16", cw_count, 16'd20);

    // Random handshakes on both sides, including injection.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      inj_en    = 1'($urandom_range(0, 1));
      inj_pos   = 6'($urandom_range(0, 63));
      cycle();
    end
    inj_en = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ecc32_encoder.md
ECC32_ENCODER -- requirements
Module: ecc32_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the delivered-codeword counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder can accept a word.
REQ-006 SHALL have port in_data, input, 32 bits: data word; bit i carries data position i (positions 0..31).
REQ-007 SHALL have port inj_en, input, 1 bit: inject a single-bit error into this word; sampled together with in_data.
REQ-008 SHALL have port inj_pos, input, 6 bits: codeword bit to flip.
REQ-009 SHALL have port out_valid, output, 1 bit: a codeword is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the codeword.
REQ-011 SHALL have port out_data, output, 32 bits: codeword data field.
REQ-012 SHALL have port out_check, output, 8 bits: codeword check field.
REQ-013 SHALL have port cw_count, output, CNT_W bits: number of codewords delivered.

Function
REQ-014 SHALL compute check[k] as the even-parity XOR of in_data & MASK[k], with MASK[0..7] = 00FF1111, FF002222, 0F0F4444, F0F08888, 111100FF, 2222FF00, 44440F0F, 8888F0F0 (hex); each mask has 12 bits set.
REQ-015 SHALL ensure that an error-free codeword gives an all-zero syndrome at the matching 32-bit SEC decoder when all check-enable inputs are 1.
REQ-016 SHALL complete an input handshake when in_valid and in_ready are both 1, and an output handshake when out_valid and out_ready are both 1.
REQ-017 SHALL present a word accepted in cycle N on the outputs from cycle N+1 at the earliest (1-cycle latency); the encoder SHALL sustain 1 word per cycle while out_ready is 1.
REQ-018 SHALL buffer 2 entries (output register plus skid register); in_ready SHALL be registered and equal to "skid register empty", with no combinational path from out_ready to in_ready.
REQ-019 SHALL hold out_valid, out_data and out_check stable while out_valid is 1 and out_ready is 0.
REQ-020 SHALL deliver words in acceptance order with no loss or duplication, including when an input handshake and an output handshake occur in the same cycle.
REQ-021 SHALL apply error injection at acceptance when inj_en is 1: inj_pos 0..31 inverts data bit inj_pos; 32..39 inverts check bit inj_pos-32; 40..63 changes nothing. Check bits SHALL always be computed from the unflipped data.
REQ-022 SHALL increment cw_count on each output handshake and saturate at all-ones (no wrap).

Reset
REQ-023 SHALL, while rst is 1, set out_valid=0, in_ready=0, out_data=0, out_check=0, cw_count=0, and empty both buffer entries.
REQ-024 SHALL set in_ready=1 in the first cycle after rst deasserts; words in flight when reset asserts mid-stream SHALL be discarded.

Structure
REQ-025 SHALL take MASK[0..7], the data width (32), the check width (8) and the injection-position limits from a shared package ecc32_pkg, which the decoder side also uses.
REQ-026 SHALL contain one sub-module, ecc32_checkgen: purely combinational, 32-bit data in, 8-bit check out, instantiated once on the input side.

Verification
REQ-027 SHALL cover: in_data=00000000 -> out_check=00; 00000001 -> 51; 80000000 -> 8A; FFFFFFFF -> 00; each appearing 1 cycle after acceptance.
REQ-028 SHALL cover: 1000 random words with out_ready held at 1 -> every decoder syndrome is 00, 1 word/cycle, cw_count=1000.
REQ-029 SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 words accepted, in_ready=0 from the third cycle, outputs stable; then out_ready=1 -> order preserved.
REQ-030 SHALL cover: inj_en=1 with inj_pos=5, 37 and 50 on in_data=00000000 -> (out_data=00000020, check=00), (00000000, 20) and (00000000, 00).
REQ-031 SHALL cover: CNT_W=4 with 20 deliveries -> cw_count holds at F.
REQ-032 SHALL cover: rst asserted for 1 cycle with 2 words buffered -> out_valid=0 and cw_count=0 in the next cycle, and the stale words are never emitted.
